psum_reduce: RTL and testbench
==============================

PSUM_REDUCE -- requirements
Module: psum_reduce

Interface
REQ-001 SHALL have parameter NUM_PE, default 8, number of PE output channels (power of 2, 2..32).
REQ-002 SHALL have parameter DATA_W, default 64, bits per PE output word.
REQ-003 SHALL have parameter ELEM_W, default 16, lane element width (DATA_W multiple of ELEM_W); LANES = DATA_W/ELEM_W.
REQ-004 SHALL have parameter SAT, default 0, where 0 = wrap-around add and 1 = signed saturating add.
REQ-005 SHALL have parameter CNT_W, default 8, accumulate-length counter width.
REQ-006 SHALL have port clk, input, 1, sole clock (rising edge).
REQ-007 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-008 SHALL have port in_valid, input, 1, input beat valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts beat.
REQ-010 SHALL have port pe_data, input, NUM_PE*DATA_W, packed PE outputs (PE0 at LSBs).
REQ-011 SHALL have port psum_in, input, DATA_W, partial sum read from GB, sampled with the beat.
REQ-012 SHALL have port mode, input, 2, where 0 = REDUCE, 1 = ADD_PSUM and 2 = ACCUM; 3 is reserved and treated as REDUCE.
REQ-013 SHALL have port acc_len, input, CNT_W, beats per ACCUM group (0 treated as 1).
REQ-014 SHALL have port clear, input, 1, synchronous abort: flush pipeline and accumulator.
REQ-015 SHALL have port out_valid, output, 1, result valid.
REQ-016 SHALL have port out_ready, input, 1, downstream (GB write) accepts.
REQ-017 SHALL have port out_data, output, DATA_W, lane-wise result.
REQ-018 SHALL have port busy, output, 1, high while any stage is valid or an ACCUM group is open.

Function
REQ-019 SHALL accept a beat when in_valid && in_ready, and SHALL define in_ready = !out_valid || out_ready (global pipeline advance).
REQ-020 SHALL reduce the NUM_PE words lane-wise via a registered binary adder tree of log2(NUM_PE) stages, then one final stage; beat-to-out_valid latency = log2(NUM_PE)+1 cycles with no stall.
REQ-021 SHALL NOT advance any stage when the advance condition is low; stalled stage contents SHALL be held unchanged.
REQ-022 SHALL carry mode and psum_in down the pipeline alongside the tree data, aligned to the beat.
REQ-023 Final stage, REDUCE: out_data = tree sum.
REQ-024 Final stage, ADD_PSUM: out_data = tree sum + psum_in.
REQ-025 Final stage, ACCUM: acc = acc + tree sum per beat; out_valid SHALL assert only on the last beat of the group, with out_data = final acc; acc SHALL then reset to 0.
REQ-026 SHALL use an accumulator FSM with states IDLE and OPEN: IDLE->OPEN on the first ACCUM beat reaching the final stage when acc_len>1; OPEN->IDLE when the beat count reaches the latched acc_len-1, or on clear.
REQ-027 SHALL latch acc_len at group open; changes mid-group SHALL be ignored.
REQ-028 SHALL finish the open group normally if a non-ACCUM beat arrives while OPEN, and that beat SHALL be processed per its own mode after the group closes (in order, no reordering).
REQ-029 When SAT=0, each lane add SHALL wrap modulo 2^ELEM_W; when SAT=1, each lane SHALL clamp to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1] at every adder.
REQ-030 Lanes SHALL be independent; no carry SHALL cross lane boundaries.
REQ-031 clear SHALL have priority over a simultaneous accept: all stage valids and out_valid go 0, acc goes 0, FSM goes IDLE, next cycle; the beat presented with clear SHALL be dropped.
REQ-032 out_data SHALL be stable while out_valid && !out_ready.

Reset
REQ-033 On rst_n low, asynchronously: all stage valids 0, out_valid 0, out_data 0, acc 0, beat counter 0, FSM IDLE, busy 0.
REQ-034 in_ready SHALL be 1 during and after reset (follows REQ-019).
REQ-035 On reset mid-group, the group SHALL be discarded and produce no output.

Structure
REQ-036 The shared package SHALL hold the mode encoding (REDUCE/ADD_PSUM/ACCUM), the FSM state encoding, and a CLOG2-style depth constant.
REQ-037 Sub-module lane_add (ELEM_W, SAT; one lane add with optional saturation) SHALL be instantiated across tree and final stage; one instance per lane per adder.

Verification
REQ-038 Reset release, NUM_PE=8, REDUCE, all PE lanes = 1 -> out_valid 4 cycles after accept, every lane = 8.
REQ-039 ADD_PSUM, PE lanes = 2, psum lanes = 100 -> lanes = 116.
REQ-040 ACCUM, acc_len=3, PE lanes = 1 for 3 beats -> single output with lanes = 24; no out_valid on beats 1-2.
REQ-041 SAT=1, PE lanes = 0x7000 -> lanes = 0x7FFF; SAT=0 -> lanes = 0x8000 (wrapped).
REQ-042 out_ready held low 5 cycles with continuous in_valid -> in_ready low, out_data held, no beat lost or duplicated after release.
REQ-043 clear asserted mid ACCUM group (after 2 of 4 beats) -> no output; next group of acc_len=1 with PE lanes = 3 -> lanes = 24.

Source files
------------

// File: rtl/psum_reduce_pkg.sv
// Shared encodings for the partial-sum reduction block: operating modes,
// accumulator FSM states and the adder-tree depth helper.
package psum_reduce_pkg;

  typedef enum logic [1:0] {
    MODE_REDUCE   = 2'd0,
    MODE_ADD_PSUM = 2'd1,
    MODE_ACCUM    = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } acc_state_e;

  // Number of pairwise adder levels needed to fold n words into one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/lane_add.sv
// One lane adder: two's-complement add that either wraps or clamps to the
// signed range of the lane.
module lane_add #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned SAT    = 0
) (
  input  logic [ELEM_W-1:0] i_a,
  input  logic [ELEM_W-1:0] i_b,
  output logic [ELEM_W-1:0] o_sum_c
);

  logic [ELEM_W:0] w_full;

  assign w_full = {i_a[ELEM_W-1], i_a} + {i_b[ELEM_W-1], i_b};

  // Overflow shows up as the two top bits of the sign-extended sum disagreeing.
  always_comb begin
    o_sum_c = w_full[ELEM_W-1:0];
    if ((SAT != 0) && (w_full[ELEM_W] != w_full[ELEM_W-1])) begin
      o_sum_c = w_full[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}}
                               : {1'b0, {(ELEM_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/psum_reduce.sv
// Lane-wise reduction of NUM_PE PE output words through a registered adder
// tree, followed by a final stage that passes, adds a partial sum, or accumulates.
module psum_reduce
  import psum_reduce_pkg::*;
#(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned SAT    = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_PE*DATA_W-1:0] pe_data,
  input  logic [DATA_W-1:0]        psum_in,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         acc_len,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy
);

  localparam int unsigned LANES   = DATA_W / ELEM_W;
  localparam int unsigned DEPTH   = clog2(NUM_PE);
  localparam int unsigned TREE_W  = (NUM_PE - 1) * DATA_W;
  localparam int unsigned LVL_W   = (2 * NUM_PE - 1) * DATA_W;
  localparam int unsigned MODE_PW = 2 * DEPTH;
  localparam int unsigned PSUM_PW = DATA_W * DEPTH;
  localparam int unsigned FIN_OFF = (2 * NUM_PE - 2) * DATA_W;

  // Tree levels packed back to back: level s holds NUM_PE>>s words.
  logic [TREE_W-1:0]  r_tree;
  logic [TREE_W-1:0]  w_tree_nxt;
  logic [LVL_W-1:0]   w_lvl;
  logic [DEPTH-1:0]   r_vld;
  logic [MODE_PW-1:0] r_mode;
  logic [PSUM_PW-1:0] r_psum;

  acc_state_e         r_state, w_nxt_state;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [CNT_W-1:0]   r_len, w_nxt_len;
  logic [DATA_W-1:0]  r_acc, w_nxt_acc;
  logic               r_out_valid, w_nxt_out_valid;
  logic [DATA_W-1:0]  r_out_data, w_nxt_out_data;

  logic [DATA_W-1:0]  w_top;
  logic [DATA_W-1:0]  w_fin_b;
  logic [DATA_W-1:0]  w_fin_sum;
  logic [1:0]         w_mode_d;
  logic [DATA_W-1:0]  w_psum_d;
  logic               w_vld_d;
  logic               w_is_acc;
  logic               w_is_add;
  logic               w_slot;
  logic               w_split;
  logic               w_adv;

  assign w_lvl = {r_tree, pe_data};

  for (genvar s = 1; s <= DEPTH; s++) begin : g_lvl
    localparam int unsigned N_OUT   = NUM_PE >> s;
    localparam int unsigned IN_OFF  = 2 * NUM_PE - 2 * (NUM_PE >> (s - 1));
    localparam int unsigned OUT_OFF = NUM_PE - 2 * N_OUT;
    for (genvar j = 0; j < N_OUT; j++) begin : g_word
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_add #(.ELEM_W(ELEM_W), .SAT(SAT)) u_add (
          .i_a    (w_lvl[(IN_OFF + 2*j) * DATA_W + l * ELEM_W +: ELEM_W]),
          .i_b    (w_lvl[(IN_OFF + 2*j + 1) * DATA_W + l * ELEM_W +: ELEM_W]),
          .o_sum_c(w_tree_nxt[(OUT_OFF + j) * DATA_W + l * ELEM_W +: ELEM_W])
        );
      end
    end
  end

  assign w_top    = w_lvl[FIN_OFF +: DATA_W];
  assign w_mode_d = r_mode[MODE_PW-1 -: 2];
  assign w_psum_d = r_psum[PSUM_PW-1 -: DATA_W];
  assign w_vld_d  = r_vld[DEPTH-1];
  assign w_is_acc = (w_mode_d == MODE_ACCUM);
  assign w_is_add = (w_mode_d == MODE_ADD_PSUM);
  assign w_fin_b  = w_is_add ? w_psum_d : (w_is_acc ? r_acc : '0);

  for (genvar l = 0; l < LANES; l++) begin : g_fin
    lane_add #(.ELEM_W(ELEM_W), .SAT(SAT)) u_add (
      .i_a    (w_top[l * ELEM_W +: ELEM_W]),
      .i_b    (w_fin_b[l * ELEM_W +: ELEM_W]),
      .o_sum_c(w_fin_sum[l * ELEM_W +: ELEM_W])
    );
  end

  // A non-ACCUM beat meeting an open group spends one frozen cycle flushing the group first.
  assign w_slot   = !r_out_valid || out_ready;
  assign w_split  = w_vld_d && (r_state == ST_OPEN) && !w_is_acc;
  assign w_adv    = w_slot && !w_split;
  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_tree <= '0;
      r_mode <= '0;
      r_psum <= '0;
    end else if (clear) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld  <= DEPTH'({r_vld, in_valid});
      r_tree <= w_tree_nxt;
      r_mode <= MODE_PW'({r_mode, mode});
      r_psum <= PSUM_PW'({r_psum, psum_in});
    end
  end

  // Final stage and accumulator group control.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_len       = r_len;
    w_nxt_acc       = r_acc;
    w_nxt_out_valid = r_out_valid;
    w_nxt_out_data  = r_out_data;
    if (clear) begin
      w_nxt_state     = ST_IDLE;
      w_nxt_cnt       = '0;
      w_nxt_acc       = '0;
      w_nxt_out_valid = 1'b0;
    end else if (w_slot) begin
      w_nxt_out_valid = 1'b0;
      if (w_split) begin
        w_nxt_out_valid = 1'b1;
        w_nxt_out_data  = r_acc;
        w_nxt_acc       = '0;
        w_nxt_cnt       = '0;
        w_nxt_state     = ST_IDLE;
      end else if (w_vld_d) begin
        if (!w_is_acc) begin
          w_nxt_out_valid = 1'b1;
          w_nxt_out_data  = w_fin_sum;
        end else if (r_state == ST_IDLE) begin
          if (acc_len > CNT_W'(1)) begin
            w_nxt_state = ST_OPEN;
            w_nxt_len   = acc_len;
            w_nxt_cnt   = CNT_W'(1);
            w_nxt_acc   = w_fin_sum;
          end else begin
            w_nxt_out_valid = 1'b1;
            w_nxt_out_data  = w_fin_sum;
          end
        end else if (r_cnt == r_len - CNT_W'(1)) begin
          w_nxt_out_valid = 1'b1;
          w_nxt_out_data  = w_fin_sum;
          w_nxt_acc       = '0;
          w_nxt_cnt       = '0;
          w_nxt_state     = ST_IDLE;
        end else begin
          w_nxt_acc = w_fin_sum;
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_len       <= w_nxt_len;
      r_acc       <= w_nxt_acc;
      r_out_valid <= w_nxt_out_valid;
      r_out_data  <= w_nxt_out_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (|r_vld) || r_out_valid || (r_state == ST_OPEN);

endmodule

// File: tb/tb_psum_reduce.sv
// Bench for psum_reduce: wrap and saturating instances share stimulus and are
// scored against a lane-wise arithmetic model of the reduction and grouping rules.
module tb_psum_reduce;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         clear;
  logic         out_ready;
  logic [511:0] pe_data;
  logic [63:0]  psum_in;
  logic [1:0]   mode;
  logic [7:0]   acc_len;

  logic         in_ready_w, out_valid_w, busy_w;
  logic         in_ready_s, out_valid_s, busy_s;
  logic [63:0]  out_data_w, out_data_s;

  always #5 clk = ~clk;

  psum_reduce #(.NUM_PE(8), .DATA_W(64), .ELEM_W(16), .SAT(0), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .pe_data(pe_data), .psum_in(psum_in), .mode(mode), .acc_len(acc_len),
    .clear(clear), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .busy(busy_w));

  psum_reduce #(.NUM_PE(8), .DATA_W(64), .ELEM_W(16), .SAT(1), .CNT_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .pe_data(pe_data), .psum_in(psum_in), .mode(mode), .acc_len(acc_len),
    .clear(clear), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .busy(busy_s));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ladd(input logic [15:0] a, input logic [15:0] b, input bit sat);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (sat) begin
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
    end
    return 16'(s);
  endfunction

  function automatic logic [63:0] vadd(input logic [63:0] a, input logic [63:0] b, input bit sat);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = ladd(a[l*16 +: 16], b[l*16 +: 16], sat);
    return r;
  endfunction

  function automatic logic [63:0] tree(input logic [511:0] pe, input bit sat);
    logic [63:0] w [8];
    int n;
    for (int i = 0; i < 8; i++) w[i] = pe[i*64 +: 64];
    n = 8;
    while (n > 1) begin
      for (int i = 0; i < n / 2; i++) w[i] = vadd(w[2*i], w[2*i+1], sat);
      n = n / 2;
    end
    return w[0];
  endfunction

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  function automatic logic [511:0] rep_pe(input logic [15:0] x);
    return {8{rep(x)}};
  endfunction

  logic [63:0] q_w[$];
  logic [63:0] q_s[$];
  bit          m_open = 1'b0;
  int          m_cnt, m_len;
  logic [63:0] m_acc_w, m_acc_s;

  task automatic push(input logic [63:0] w, input logic [63:0] s);
    q_w.push_back(w);
    q_s.push_back(s);
  endtask

  task automatic model_beat(input logic [511:0] pe, input logic [63:0] ps,
                            input logic [1:0] md, input int len);
    logic [63:0] tw, ts;
    tw = tree(pe, 1'b0);
    ts = tree(pe, 1'b1);
    if (md == 2'd2) begin
      if (!m_open) begin
        if (len <= 1) push(tw, ts);
        else begin
          m_open = 1'b1; m_len = len; m_cnt = 1; m_acc_w = tw; m_acc_s = ts;
        end
      end else begin
        m_acc_w = vadd(m_acc_w, tw, 1'b0);
        m_acc_s = vadd(m_acc_s, ts, 1'b1);
        m_cnt++;
        if (m_cnt == m_len) begin
          push(m_acc_w, m_acc_s);
          m_open = 1'b0;
        end
      end
    end else begin
      if (m_open) begin
        push(m_acc_w, m_acc_s);
        m_open = 1'b0;
      end
      if (md == 2'd1) push(vadd(tw, ps, 1'b0), vadd(ts, ps, 1'b1));
      else push(tw, ts);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          n_out = 0;
  logic [63:0] last_w, last_s;
  bit          stall_prev = 1'b0;
  logic [63:0] held_w, held_s;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid_w), 64'd1);
        check("hold_data_wrap", out_data_w, held_w);
        check("hold_data_sat", out_data_s, held_s);
      end
      stall_prev = out_valid_w && !out_ready && !clear;
      held_w = out_data_w;
      held_s = out_data_s;
      if (out_valid_w && out_ready) begin
        n_out++;
        last_w = out_data_w;
        last_s = out_data_s;
        check("out_expected", 64'(q_w.size() > 0), 64'd1);
        check("sat_valid", 64'(out_valid_s), 64'd1);
        if (q_w.size() > 0) begin
          check("data_wrap", out_data_w, q_w.pop_front());
          check("data_sat", out_data_s, q_s.pop_front());
        end
      end
      if (clear) m_open = 1'b0;
      else if (in_valid && in_ready_w) model_beat(pe_data, psum_in, mode, int'(acc_len));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [511:0] pe, input logic [63:0] ps, input logic [1:0] md);
    bit ok;
    ok = 1'b0;
    pe_data = pe; psum_in = ps; mode = md; in_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready_w;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("beat_accept", 64'(ok), 64'd1);
  endtask

  function automatic logic [511:0] rand_pe();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  int  n0, lat;
  bit  found, done;
  int  seg_len [4] = '{0, 1, 3, 5};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    pe_data = '0; psum_in = '0; mode = 2'd0; acc_len = 8'd1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready_w), 64'd1);
    check("rst_out_valid", 64'(out_valid_w), 64'd0);
    check("rst_busy", 64'(busy_w), 64'd0);
    check("rst_out_data", out_data_w, 64'd0);
    check("rst_out_data_sat", out_data_s, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    check("post_rst_in_ready", 64'(in_ready_w), 64'd1);

    // REDUCE, all ones: latency and value
    n0 = n_out;
    beat(rep_pe(16'd1), 64'd0, 2'd0);
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!found && out_valid_w) begin lat = k; found = 1'b1; end
    end
    @(posedge clk); #1;
    check("reduce_latency", 64'(lat), 64'd4);
    check("reduce_count", 64'(n_out - n0), 64'd1);
    check("reduce_value", last_w, rep(16'd8));

    // ADD_PSUM
    beat(rep_pe(16'd2), rep(16'd100), 2'd1);
    idle(8);
    check("add_psum_wrap", last_w, rep(16'd116));
    check("add_psum_sat", last_s, rep(16'd116));

    // ACCUM group of 3
    acc_len = 8'd3; n0 = n_out;
    repeat (3) beat(rep_pe(16'd1), 64'd0, 2'd2);
    idle(8);
    check("accum3_count", 64'(n_out - n0), 64'd1);
    check("accum3_value", last_w, rep(16'd24));

    // saturation vs wrap
    beat(rep_pe(16'h7000), 64'd0, 2'd0);
    idle(8);
    check("wrap_7000", last_w, rep(16'h8000));
    check("sat_7000", last_s, rep(16'h7fff));

    // backpressure with continuous input
    n0 = n_out; out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) beat(rand_pe(), 64'd0, 2'd0);
      end
      begin
        idle(9);
        check("bp_in_ready_low", 64'(in_ready_w), 64'd0);
        check("bp_out_valid", 64'(out_valid_w), 64'd1);
        out_ready = 1'b1;
      end
    join
    idle(10);
    check("bp_count", 64'(n_out - n0), 64'd8);

    // acc_len change mid-group is ignored
    acc_len = 8'd2; n0 = n_out;
    beat(rep_pe(16'd1), 64'd0, 2'd2);
    idle(6);
    check("latch_open_busy", 64'(busy_w), 64'd1);
    acc_len = 8'd5;
    beat(rep_pe(16'd3), 64'd0, 2'd2);
    idle(6);
    check("latch_count", 64'(n_out - n0), 64'd1);
    check("latch_value", last_w, rep(16'd32));

    // non-ACCUM beat closes the open group, then is processed in order
    acc_len = 8'd3; n0 = n_out;
    beat(rep_pe(16'd1), 64'd0, 2'd2);
    beat(rep_pe(16'd1), 64'd0, 2'd2);
    beat(rep_pe(16'd5), 64'd0, 2'd0);
    idle(10);
    check("split_count", 64'(n_out - n0), 64'd2);
    check("split_last", last_w, rep(16'd40));
    check("split_busy", 64'(busy_w), 64'd0);

    // clear mid-group drops the group and the concurrent beat
    acc_len = 8'd4; n0 = n_out;
    beat(rep_pe(16'd1), 64'd0, 2'd2);
    beat(rep_pe(16'd1), 64'd0, 2'd2);
    idle(6);
    check("clear_pre_busy", 64'(busy_w), 64'd1);
    clear = 1'b1; in_valid = 1'b1; pe_data = rep_pe(16'd9); mode = 2'd0;
    idle(1);
    clear = 1'b0; in_valid = 1'b0;
    check("clear_busy", 64'(busy_w), 64'd0);
    idle(6);
    check("clear_no_out", 64'(n_out - n0), 64'd0);
    acc_len = 8'd1;
    beat(rep_pe(16'd3), 64'd0, 2'd2);
    idle(6);
    check("after_clear_count", 64'(n_out - n0), 64'd1);
    check("after_clear_value", last_w, rep(16'd24));

    // random segments against the model
    for (int sg = 0; sg < 4; sg++) begin
      acc_len = 8'(seg_len[sg]);
      done = 1'b0;
      fork
        begin
          for (int b = 0; b < 30; b++) begin
            beat(rand_pe(), {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(1);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      out_ready = 1'b1;
      idle(8);
    end
    check("queue_drained", 64'(q_w.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
